instr_fetch_unit: RTL and testbench

Program-counter and fetch sequencer for the bbtron-enhanced single-issue core. It sits directly upstream of the control unit: it drives the instruction-memory address, presents the fetched word so its opcode field feeds the control unit, and consumes the control unit's jump, branch, halt, in and reset flags to choose the next PC. It also qualifies every datapath write with a single-cycle execute strobe and holds the core during halt and user-input waits.

---
 rtl/instr_fetch_unit.sv | 185 ++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : PC / fetch sequencer for the single-issue core: drives the ROM
//            address, qualifies execution, and handles branch, jump, halt,
//            user-input wait and soft reset. Optional macro: IN_SYNC_EN adds
//            a 2-flop synchronizer on in_ack.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int                    ADDR_WIDTH = 10,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_rdata,
    output logic [31:0]           instr,
    output logic [ADDR_WIDTH-1:0] pc_plus1,
    input  logic                  cu_Jump,
    input  logic                  cu_Branch,
    input  logic                  cu_hlt,
    input  logic                  cu_reset,
    input  logic                  cu_inSignal,
    input  logic                  alu_zero,
    input  logic                  in_ack,
    output logic                  exec_en,
    output logic                  waiting_in,
    output logic                  halted,
    output logic                  soft_rst,
    output logic [CNT_WIDTH-1:0]  instr_count
);

    localparam logic [5:0] c_OP_BEQ = 6'b001001;
    localparam logic [5:0] c_OP_BNE = 6'b001010;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_EXEC    = 2'd1,
        S_WAIT_IN = 2'd2,
        S_HALT    = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_pc_nxt;
    logic [ADDR_WIDTH-1:0] w_pc_plus1;
    logic [ADDR_WIDTH-1:0] w_off;
    logic [ADDR_WIDTH-1:0] w_br_tgt;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  r_soft_rst;
    logic                  w_soft_nxt;
    logic                  w_cnt_clr;
    logic                  w_exec;
    logic                  w_taken;
    logic [5:0]            w_opcode;
    logic                  w_ack_lvl;
    logic                  r_ack_q;
    logic                  r_ack_qq;
    logic                  w_ack_rise;

`ifdef IN_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], in_ack};
        end
    end

    assign w_ack_lvl = r_sync[1];
`else
    assign w_ack_lvl = in_ack;
`endif

    // Edge detector runs every cycle so stale edges never reach WAIT_IN.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack_q  <= 1'b0;
            r_ack_qq <= 1'b0;
        end else begin
            r_ack_q  <= w_ack_lvl;
            r_ack_qq <= r_ack_q;
        end
    end

    assign w_ack_rise = r_ack_q & ~r_ack_qq;

    assign w_opcode   = imem_rdata[31:26];
    assign w_pc_plus1 = r_pc + ADDR_WIDTH'(1);

    if (ADDR_WIDTH <= 16) begin : g_off_trunc
        assign w_off = imem_rdata[ADDR_WIDTH-1:0];
    end else begin : g_off_sext
        assign w_off = {{(ADDR_WIDTH-16){imem_rdata[15]}}, imem_rdata[15:0]};
    end

    assign w_br_tgt = w_pc_plus1 + w_off;
    assign w_taken  = (w_opcode == c_OP_BEQ) ? alu_zero :
                      (w_opcode == c_OP_BNE) ? ~alu_zero : 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_pc       <= RESET_ADDR;
            r_count    <= '0;
            r_soft_rst <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_soft_rst <= w_soft_nxt;
            if (w_cnt_clr) begin
                r_count <= '0;
            end else if (w_exec) begin
                r_count <= r_count + CNT_WIDTH'(1);
            end
        end
    end

    // Flag priority in EXEC is fixed; lower flags are don't-care when masked.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_exec      = 1'b0;
        w_soft_nxt  = 1'b0;
        w_cnt_clr   = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (cu_reset) begin
                    w_pc_nxt    = RESET_ADDR;
                    w_cnt_clr   = 1'b1;
                    w_soft_nxt  = 1'b1;
                    w_state_nxt = S_FETCH;
                end else if (cu_hlt) begin
                    w_state_nxt = S_HALT;
                end else if (cu_Jump) begin
                    w_pc_nxt    = imem_rdata[ADDR_WIDTH-1:0];
                    w_exec      = 1'b1;
                    w_state_nxt = S_FETCH;
                end else if (cu_Branch) begin
                    w_pc_nxt    = w_taken ? w_br_tgt : w_pc_plus1;
                    w_exec      = 1'b1;
                    w_state_nxt = S_FETCH;
                end else if (cu_inSignal) begin
                    w_state_nxt = S_WAIT_IN;
                end else begin
                    w_pc_nxt    = w_pc_plus1;
                    w_exec      = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            S_WAIT_IN: begin
                if (w_ack_rise) begin
                    w_pc_nxt    = w_pc_plus1;
                    w_exec      = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    assign imem_addr   = r_pc;
    assign instr       = imem_rdata;
    assign pc_plus1    = w_pc_plus1;
    assign exec_en     = w_exec;
    assign waiting_in  = (r_state == S_WAIT_IN);
    assign halted      = (r_state == S_HALT);
    assign soft_rst    = r_soft_rst;
    assign instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Self-checking bench: ROM + control-unit model, table-driven PC
//            vectors and hand sequences for halt, user-input wait and resets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam int AW = 10;
    localparam logic [5:0] c_OP_ADD = 6'b000000;
    localparam logic [5:0] c_OP_JMP = 6'b000010;
    localparam logic [5:0] c_OP_BEQ = 6'b001001;
    localparam logic [5:0] c_OP_BNE = 6'b001010;
    localparam logic [5:0] c_OP_IN  = 6'b010000;
    localparam logic [5:0] c_OP_RST = 6'b111110;
    localparam logic [5:0] c_OP_HLT = 6'b111111;
`ifdef IN_SYNC_EN
    localparam int c_EXP_LAT = 3;
`else
    localparam int c_EXP_LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic [31:0]   instr;
    logic [AW-1:0] pc_plus1;
    logic          cu_Jump, cu_Branch, cu_hlt, cu_reset, cu_inSignal;
    logic          alu_zero = 1'b0;
    logic          in_ack = 1'b0;
    logic          exec_en, waiting_in, halted, soft_rst;
    logic [15:0]   instr_count;

    logic [31:0]   rom [0:(1<<AW)-1];
    int            total = 0;
    int            bad = 0;
    logic [AW-1:0] exp_q [$];

    instr_fetch_unit dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instr(instr), .pc_plus1(pc_plus1), .cu_Jump(cu_Jump), .cu_Branch(cu_Branch),
        .cu_hlt(cu_hlt), .cu_reset(cu_reset), .cu_inSignal(cu_inSignal),
        .alu_zero(alu_zero), .in_ack(in_ack), .exec_en(exec_en),
        .waiting_in(waiting_in), .halted(halted), .soft_rst(soft_rst),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Synchronous ROM with one-cycle read latency.
    always @(posedge clk) imem_rdata <= rom[imem_addr];

    // Control-unit decode model.
    always_comb begin
        cu_Jump = 1'b0; cu_Branch = 1'b0; cu_hlt = 1'b0; cu_reset = 1'b0; cu_inSignal = 1'b0;
        case (instr[31:26])
            c_OP_JMP: cu_Jump     = 1'b1;
            c_OP_BEQ: cu_Branch   = 1'b1;
            c_OP_BNE: cu_Branch   = 1'b1;
            c_OP_IN:  cu_inSignal = 1'b1;
            c_OP_RST: cu_reset    = 1'b1;
            c_OP_HLT: cu_hlt      = 1'b1;
            default: ;
        endcase
    end

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [25:0] low);
        return {op, low};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc"},       32'(imem_addr),   32'd0);
        chk({tag, "_count"},    32'(instr_count), 32'd0);
        chk({tag, "_exec_en"},  32'(exec_en),     32'd0);
        chk({tag, "_waiting"},  32'(waiting_in),  32'd0);
        chk({tag, "_halted"},   32'(halted),      32'd0);
        chk({tag, "_soft_rst"}, 32'(soft_rst),    32'd0);
    endtask

    task automatic clear_rom();
        for (int a = 0; a < (1 << AW); a++) rom[a] = enc(c_OP_ADD, 26'd0);
    endtask

    typedef struct {
        logic [AW-1:0] pc_start;
        logic [31:0]   word;
        logic          zero;
        logic [AW-1:0] exp_pc;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{10'd5,    enc(c_OP_BEQ, 26'h000FFFD), 1'b1, 10'd3};
        vecs[1] = '{10'd5,    enc(c_OP_BEQ, 26'h000FFFD), 1'b0, 10'd6};
        vecs[2] = '{10'd5,    enc(c_OP_BNE, 26'h000FFFD), 1'b0, 10'd3};
        vecs[3] = '{10'd5,    enc(c_OP_BNE, 26'h000FFFD), 1'b1, 10'd6};
        vecs[4] = '{10'd7,    enc(c_OP_JMP, 26'h00003FF), 1'b0, 10'd1023};
        vecs[5] = '{10'd1023, enc(c_OP_ADD, 26'd0),       1'b0, 10'd0};
        vecs[6] = '{10'd1,    enc(c_OP_BEQ, 26'h000FFFD), 1'b1, 10'd1023};

        // Table-driven PC update vectors: jump from 0 to pc_start, execute word.
        clear_rom();
        for (int i = 0; i < 7; i++) begin
            rom[0]               = enc(c_OP_JMP, 26'(vecs[i].pc_start));
            rom[vecs[i].pc_start] = vecs[i].word;
            alu_zero             = vecs[i].zero;
            exp_q.push_back(vecs[i].exp_pc);
            do_reset();
            tick();
            tick();
            chk($sformatf("v%0d_start_pc", i), 32'(imem_addr), 32'(vecs[i].pc_start));
            tick();
            chk($sformatf("v%0d_exec_en", i), 32'(exec_en), 32'd1);
            tick();
            chk($sformatf("v%0d_next_pc", i), 32'(imem_addr), 32'(exp_q.pop_front()));
            chk($sformatf("v%0d_count", i), 32'(instr_count), 32'd2);
            rom[vecs[i].pc_start] = enc(c_OP_ADD, 26'd0);
        end
        alu_zero = 1'b0;

        // Add, Add, Hlt from reset, then hardware reset out of HALT.
        begin
            logic [7:0] ep, hp;
            int         drift;
            clear_rom();
            rom[2] = enc(c_OP_HLT, 26'd0);
            do_reset();
            chk_reset_vals("rst0");
            for (int c = 0; c < 8; c++) begin
                ep[c] = exec_en;
                hp[c] = halted;
                tick();
            end
            chk("halt_exec_pattern", 32'(ep), 32'h0A);
            chk("halt_halted_pattern", 32'(hp), 32'hC0);
            chk("halt_count", 32'(instr_count), 32'd2);
            drift = 0;
            for (int c = 0; c < 20; c++) begin
                if (imem_addr !== 10'd2 || exec_en !== 1'b0 || halted !== 1'b1) drift++;
                tick();
            end
            chk("halt_frozen", 32'(drift), 32'd0);
            do_reset();
            chk_reset_vals("rst_halt");
            tick();
            chk("rst_halt_resume", 32'(exec_en), 32'd1);
        end

        // In at pc=4 with a stale in_ack pulse before entry.
        begin
            int hold_bad;
            int lat;
            clear_rom();
            rom[0] = enc(c_OP_JMP, 26'd4);
            rom[4] = enc(c_OP_IN, 26'd0);
            do_reset();
            in_ack = 1'b1;
            tick();
            in_ack = 1'b0;
            tick();
            tick();
            chk("in_exec_stage_en", 32'(exec_en), 32'd0);
            tick();
            hold_bad = 0;
            for (int c = 0; c < 50; c++) begin
                if (waiting_in !== 1'b1 || exec_en !== 1'b0 || imem_addr !== 10'd4 ||
                    instr !== enc(c_OP_IN, 26'd0)) hold_bad++;
                tick();
            end
            chk("in_wait_hold", 32'(hold_bad), 32'd0);
            lat = 0;
            in_ack = 1'b1;
            do begin
                tick();
                lat++;
                if (lat == 1) in_ack = 1'b0;
            end while (exec_en !== 1'b1 && lat < 10);
            chk("in_ack_latency", 32'(lat), 32'(c_EXP_LAT));
            tick();
            chk("in_next_pc", 32'(imem_addr), 32'd5);
            chk("in_wait_clear", 32'(waiting_in), 32'd0);
            chk("in_count", 32'(instr_count), 32'd2);

            // Hardware reset in the middle of WAIT_IN.
            do_reset();
            tick(); tick(); tick(); tick();
            chk("rst_wait_entered", 32'(waiting_in), 32'd1);
            do_reset();
            chk_reset_vals("rst_wait");
            tick();
            chk("rst_wait_resume", 32'(exec_en), 32'd1);
        end

        // Reset opcode at pc=9 after nine retired Adds.
        clear_rom();
        rom[9] = enc(c_OP_RST, 26'd0);
        do_reset();
        for (int c = 0; c < 18; c++) tick();
        chk("srst_pc_before", 32'(imem_addr), 32'd9);
        chk("srst_count_before", 32'(instr_count), 32'd9);
        tick();
        chk("srst_exec_en", 32'(exec_en), 32'd0);
        chk("srst_pulse_early", 32'(soft_rst), 32'd0);
        tick();
        chk("srst_pulse", 32'(soft_rst), 32'd1);
        chk("srst_pc", 32'(imem_addr), 32'd0);
        chk("srst_count", 32'(instr_count), 32'd0);
        tick();
        chk("srst_pulse_end", 32'(soft_rst), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
